// File: rtl/max7219_chain_if_pkg.sv
// Shared constants and FSM state type for the MAX7219 daisy-chain serializer.
package max7219_pkg;

    localparam int          C_MAX7219_WORD_WIDTH = 16;
    localparam logic [15:0] C_MAX7219_NOOP       = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LOW,
        ST_SHIFT_HIGH,
        ST_LOAD,
        ST_DONE
    } max7219_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max7219_chain_if_if.sv
// Request/serial-bus bundle between a frame producer and max7219_chain_if.
// MAX7219_CHAIN_IF_NOOP_MASK_EN adds the per-word no-op mask input.
interface max7219_chain_if_if
    import max7219_pkg::*;
#(
    parameter int G_NB_MATRIX = 8
);
    logic                                          i_start;
    logic                                          i_en_load;
    logic [C_MAX7219_WORD_WIDTH*G_NB_MATRIX-1:0]   i_data;
`ifdef MAX7219_CHAIN_IF_NOOP_MASK_EN
    logic [G_NB_MATRIX-1:0]                        i_word_mask;
`endif
    logic                                          o_max7219_load;
    logic                                          o_max7219_data;
    logic                                          o_max7219_clk;
    logic                                          o_busy;
    logic                                          o_done;

    modport master (
`ifdef MAX7219_CHAIN_IF_NOOP_MASK_EN
        output i_word_mask,
`endif
        output i_start, i_en_load, i_data,
        input  o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done
    );

    modport slave (
`ifdef MAX7219_CHAIN_IF_NOOP_MASK_EN
        input  i_word_mask,
`endif
        input  i_start, i_en_load, i_data,
        output o_max7219_load, o_max7219_data, o_max7219_clk, o_busy, o_done
    );

endinterface

// File: rtl/max7219_chain_if_tick_timer.sv
// Down-counter: load a duration, expire_o pulses during the last cycle of it.
module max7219_tick_timer #(
    parameter int G_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [G_WIDTH-1:0] load_val_i,
    output logic               expire_o
);

    logic [G_WIDTH-1:0] cnt_q;
    logic [G_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == G_WIDTH'(1));

endmodule

// File: rtl/max7219_chain_if.sv
// Serializes one frame (one 16-bit word per cascaded MAX7219) onto DIN/CLK/LOAD.
// MAX7219_CHAIN_IF_NOOP_MASK_EN: masked words are sent as no-op words.
module max7219_chain_if
    import max7219_pkg::*;
#(
    parameter int G_NB_MATRIX       = 8,
    parameter int G_MAX_HALF_PERIOD = 4,
    parameter int G_LOAD_DURATION   = 4
) (
    input logic               clk,
    input logic               rst_n,
    max7219_chain_if_if.slave bus
);

    localparam int C_NBITS = C_MAX7219_WORD_WIDTH * G_NB_MATRIX;
    localparam int C_BW    = $clog2(C_NBITS);
    localparam int C_TW    = $clog2(max_int(G_MAX_HALF_PERIOD, G_LOAD_DURATION) + 1);

    localparam logic [C_BW-1:0] C_LAST_BIT = C_BW'(C_NBITS - 1);
    localparam logic [C_TW-1:0] C_HALF     = C_TW'(G_MAX_HALF_PERIOD);
    localparam logic [C_TW-1:0] C_LOADDUR  = C_TW'(G_LOAD_DURATION);

    max7219_state_e     state_q;
    logic [C_NBITS-1:0] shreg_q;
    logic [C_BW-1:0]    bit_cnt_q;
    logic               en_load_q;
    logic               load_q;
    logic               data_q;
    logic               sclk_q;
    logic               busy_q;
    logic               done_q;

    logic [C_NBITS-1:0] masked_data_d;
    logic               tmr_load;
    logic [C_TW-1:0]    tmr_val;
    logic               tmr_expire;

    always_comb begin
        masked_data_d = bus.i_data;
`ifdef MAX7219_CHAIN_IF_NOOP_MASK_EN
        for (int k = 0; k < G_NB_MATRIX; k++) begin
            if (bus.i_word_mask[k]) begin
                masked_data_d[k*C_MAX7219_WORD_WIDTH +: C_MAX7219_WORD_WIDTH] = C_MAX7219_NOOP;
            end
        end
`endif
    end

    // The timer is reloaded on the same edge the FSM enters a timed state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = C_HALF;
        case (state_q)
            ST_IDLE:       tmr_load = bus.i_start;
            ST_SHIFT_LOW:  tmr_load = tmr_expire;
            ST_SHIFT_HIGH: begin
                if (tmr_expire) begin
                    if (bit_cnt_q != C_LAST_BIT) begin
                        tmr_load = 1'b1;
                    end else if (en_load_q) begin
                        tmr_load = 1'b1;
                        tmr_val  = C_LOADDUR;
                    end
                end
            end
            default: ;
        endcase
    end

    max7219_tick_timer #(
        .G_WIDTH (C_TW)
    ) u_tick_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            en_load_q <= 1'b0;
            load_q    <= 1'b0;
            data_q    <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_q   <= ST_SHIFT_LOW;
                        en_load_q <= bus.i_en_load;
                        data_q    <= masked_data_d[C_NBITS-1];
                        shreg_q   <= {masked_data_d[C_NBITS-2:0], 1'b0};
                        bit_cnt_q <= '0;
                        sclk_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SHIFT_LOW: begin
                    if (tmr_expire) begin
                        state_q <= ST_SHIFT_HIGH;
                        sclk_q  <= 1'b1;
                    end
                end
                ST_SHIFT_HIGH: begin
                    if (tmr_expire) begin
                        sclk_q <= 1'b0;
                        if (bit_cnt_q != C_LAST_BIT) begin
                            state_q   <= ST_SHIFT_LOW;
                            data_q    <= shreg_q[C_NBITS-1];
                            shreg_q   <= {shreg_q[C_NBITS-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else begin
                            data_q    <= 1'b0;
                            bit_cnt_q <= '0;
                            shreg_q   <= {G_NB_MATRIX{C_MAX7219_NOOP}};
                            if (en_load_q) begin
                                state_q <= ST_LOAD;
                                load_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (tmr_expire) begin
                        state_q <= ST_DONE;
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    load_q  <= 1'b0;
                    data_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_max7219_load = load_q;
    assign bus.o_max7219_data = data_q;
    assign bus.o_max7219_clk  = sclk_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;

endmodule

// File: tb/tb_max7219_chain_if.sv
// Directed bench for max7219_chain_if: an 8-device/H=4/L=4 instance and a 1-device/H=1/L=1 instance.
// Define MAX7219_CHAIN_IF_NOOP_MASK_EN to also exercise the no-op word mask.
module tb_max7219_chain_if;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int assertCount = 0;
    int failCount   = 0;

    max7219_chain_if_if #(.G_NB_MATRIX(8)) busA ();
    max7219_chain_if_if #(.G_NB_MATRIX(1)) busB ();

    max7219_chain_if #(
        .G_NB_MATRIX       (8),
        .G_MAX_HALF_PERIOD (4),
        .G_LOAD_DURATION   (4)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    max7219_chain_if #(
        .G_NB_MATRIX       (1),
        .G_MAX_HALF_PERIOD (1),
        .G_LOAD_DURATION   (1)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitors sample on the falling edge, half a cycle away from DUT updates.
    logic [127:0] capA;
    int           edgesA, loadsA, doneA, doneCycA, startCycA;
    logic         busyAtDoneA;
    logic         prevClkA = 1'b0;

    always @(negedge clk) begin
        if (busA.o_max7219_clk && !prevClkA) begin
            capA = {capA[126:0], busA.o_max7219_data};
            edgesA++;
        end
        prevClkA = busA.o_max7219_clk;
        if (busA.o_max7219_load) loadsA++;
        if (busA.o_done) begin
            doneA++;
            doneCycA    = cyc;
            busyAtDoneA = busA.o_busy;
        end
    end

    logic [15:0] capB;
    int          edgesB, loadsB, doneB, doneCycB, startCycB, firstRiseB, secondRiseB;
    logic        prevClkB = 1'b0;

    always @(negedge clk) begin
        if (busB.o_max7219_clk && !prevClkB) begin
            capB = {capB[14:0], busB.o_max7219_data};
            if (edgesB == 0) firstRiseB = cyc;
            else if (edgesB == 1) secondRiseB = cyc;
            edgesB++;
        end
        prevClkB = busB.o_max7219_clk;
        if (busB.o_max7219_load) loadsB++;
        if (busB.o_done) begin
            doneB++;
            doneCycB = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Starts a frame on DUT A, then scrambles the inputs to show they were latched.
    task automatic applyStimulus(input logic enLoad, input logic [127:0] data);
        @(negedge clk);
        capA = '0; edgesA = 0; loadsA = 0; doneA = 0; doneCycA = -1; busyAtDoneA = 1'bx;
        busA.i_data    = data;
        busA.i_en_load = enLoad;
        busA.i_start   = 1'b1;
        startCycA      = cyc;
        @(negedge clk);
        busA.i_start   = 1'b0;
        busA.i_data    = ~data;
        busA.i_en_load = ~enLoad;
    endtask

    task automatic waitDoneA(input bit poke);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (busA.o_done === 1'b1) begin
                found = 1'b1;
                if (poke) busA.i_start = 1'b1;
            end
        end
        checkOutput("A done seen", 128'(found), 128'(1'b1));
        @(negedge clk);
        busA.i_start = 1'b0;
    endtask

    localparam logic [127:0] PAT_0C01 = {16'h0C01, 112'h0};
    localparam logic [127:0] ALL_ONES = {128{1'b1}};

    initial begin
        bit foundB;
        busA.i_start = 1'b0; busA.i_en_load = 1'b0; busA.i_data = '0;
        busB.i_start = 1'b0; busB.i_en_load = 1'b0; busB.i_data = '0;
`ifdef MAX7219_CHAIN_IF_NOOP_MASK_EN
        busA.i_word_mask = '0;
        busB.i_word_mask = '0;
`endif
        $display("[TB] reset");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("A reset outputs",
                    128'({busA.o_max7219_load, busA.o_max7219_data, busA.o_max7219_clk, busA.o_busy, busA.o_done}),
                    128'(5'b0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] frame with load");
        applyStimulus(1'b1, PAT_0C01);
        repeat (8) @(negedge clk);
        checkOutput("A busy mid-frame", 128'(busA.o_busy), 128'(1'b1));
        waitDoneA(1'b0);
        checkOutput("A latency load", 128'(doneCycA - startCycA), 128'(1029));
        checkOutput("A bits load", capA, PAT_0C01);
        checkOutput("A clk edges", 128'(edgesA), 128'(128));
        checkOutput("A load cycles", 128'(loadsA), 128'(4));
        checkOutput("A done count", 128'(doneA), 128'(1));
        checkOutput("A busy at done", 128'(busyAtDoneA), 128'(1'b0));

        $display("[TB] frame without load, start poked during DONE");
        applyStimulus(1'b0, PAT_0C01);
        waitDoneA(1'b1);
        checkOutput("A busy after DONE start", 128'(busA.o_busy), 128'(1'b0));
        @(negedge clk);
        checkOutput("A idle after DONE start", 128'({busA.o_busy, busA.o_max7219_clk}), 128'(2'b00));
        checkOutput("A latency noload", 128'(doneCycA - startCycA), 128'(1025));
        checkOutput("A bits noload", capA, PAT_0C01);
        checkOutput("A no load pulse", 128'(loadsA), 128'(0));

        $display("[TB] second start while busy");
        applyStimulus(1'b1, PAT_0C01);
        repeat (99) @(negedge clk);
        busA.i_data  = ALL_ONES;
        busA.i_start = 1'b1;
        @(negedge clk);
        busA.i_start = 1'b0;
        waitDoneA(1'b0);
        repeat (40) @(negedge clk);
        checkOutput("A single done", 128'(doneA), 128'(1));
        checkOutput("A bits unaffected", capA, PAT_0C01);
        checkOutput("A latency unaffected", 128'(doneCycA - startCycA), 128'(1029));
        checkOutput("A idle after frame", 128'(busA.o_busy), 128'(1'b0));

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, ALL_ONES);
        repeat (499) @(negedge clk);
        checkOutput("A busy before reset", 128'({busA.o_busy, busA.o_max7219_data}), 128'(2'b11));
        rst_n = 1'b0;
        #1;
        checkOutput("A outputs on reset",
                    128'({busA.o_max7219_load, busA.o_max7219_data, busA.o_max7219_clk, busA.o_busy, busA.o_done}),
                    128'(5'b0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("A no resume", 128'({busA.o_busy, busA.o_max7219_clk}), 128'(2'b00));
        applyStimulus(1'b1, PAT_0C01);
        waitDoneA(1'b0);
        checkOutput("A latency after reset", 128'(doneCycA - startCycA), 128'(1029));
        checkOutput("A bits after reset", capA, PAT_0C01);
        checkOutput("A edges after reset", 128'(edgesA), 128'(128));

        $display("[TB] single device, H=1, L=1");
        @(negedge clk);
        capB = '0; edgesB = 0; loadsB = 0; doneB = 0; doneCycB = -1; firstRiseB = -1; secondRiseB = -1;
        busB.i_data    = 16'hA5F0;
        busB.i_en_load = 1'b1;
        busB.i_start   = 1'b1;
        startCycB      = cyc;
        @(negedge clk);
        busB.i_start   = 1'b0;
        busB.i_data    = 16'h0000;
        foundB = 1'b0;
        for (int i = 0; i < 200 && !foundB; i++) begin
            @(negedge clk);
            if (busB.o_done === 1'b1) foundB = 1'b1;
        end
        @(negedge clk);
        checkOutput("B done seen", 128'(foundB), 128'(1'b1));
        checkOutput("B latency", 128'(doneCycB - startCycB), 128'(34));
        checkOutput("B bits", 128'(capB), 128'(16'hA5F0));
        checkOutput("B clk edges", 128'(edgesB), 128'(16));
        checkOutput("B clk period", 128'(secondRiseB - firstRiseB), 128'(2));
        checkOutput("B load cycles", 128'(loadsB), 128'(1));

`ifdef MAX7219_CHAIN_IF_NOOP_MASK_EN
        $display("[TB] no-op word mask");
        busA.i_word_mask = 8'h02;
        applyStimulus(1'b1, ALL_ONES);
        busA.i_word_mask = 8'hFD;
        waitDoneA(1'b0);
        checkOutput("A masked bits", capA, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_FFFF);
        checkOutput("A masked latency", 128'(doneCycA - startCycA), 128'(1029));
        checkOutput("A masked edges", 128'(edgesA), 128'(128));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/max7219_chain_if.md
MAX7219_CHAIN_IF -- requirements
Module: max7219_chain_if

Interface
REQ-001 G_NB_MATRIX, 8, number of cascaded MAX7219 devices per frame (1..16).
REQ-002 G_MAX_HALF_PERIOD, 4, clk cycles per max7219_clk half-period (>=1).
REQ-003 G_LOAD_DURATION, 4, clk cycles o_max7219_load is held high (>=1).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_start  in  1  one-cycle frame request; honoured only when idle.
REQ-007 i_en_load  in  1  1: generate LOAD pulse at frame end; 0: shift only.
REQ-008 i_data  in  16*G_NB_MATRIX  word k in bits [16k+15:16k]; word 0 = matrix nearest DIN.
REQ-009 o_max7219_load  out  1  LOAD/CS to chain; idle low.
REQ-010 o_max7219_data  out  1  serial DIN.
REQ-011 o_max7219_clk  out  1  serial CLK; idle low.
REQ-012 o_busy  out  1  high from cycle after accepted start until cycle before o_done.
REQ-013 o_done  out  1  one-cycle pulse at frame end.

Function
REQ-014 FSM states IDLE, SHIFT_LOW, SHIFT_HIGH, LOAD, DONE; SHALL leave IDLE only on i_start=1.
REQ-015 On accepted start, i_data and i_en_load SHALL be latched; later changes ignored until DONE.
REQ-016 Bit order: word G_NB_MATRIX-1 first, MSB first; word 0 bit 0 last; 16*G_NB_MATRIX bits total.
REQ-017 Each bit: SHIFT_LOW G_MAX_HALF_PERIOD cycles (clk low, data stable), then SHIFT_HIGH G_MAX_HALF_PERIOD cycles (clk high, data unchanged).
REQ-018 First SHIFT_LOW cycle SHALL be the cycle after i_start is sampled; data SHALL change only on entry to SHIFT_LOW.
REQ-019 After last SHIFT_HIGH: latched en_load=1 -> LOAD for G_LOAD_DURATION cycles with load high, clk low; else go directly to DONE.
REQ-020 DONE lasts one cycle: o_done=1, o_busy=0, then IDLE; i_start in DONE SHALL be ignored.
REQ-021 Start-to-done latency SHALL be 32*G_NB_MATRIX*G_MAX_HALF_PERIOD + (en_load ? G_LOAD_DURATION : 0) + 1 cycles.
REQ-022 i_start while o_busy=1 SHALL be dropped with no effect on the frame in progress.
REQ-023 Bit counter width SHALL be $clog2(16*G_NB_MATRIX); tick counter width $clog2(max(G_MAX_HALF_PERIOD,G_LOAD_DURATION)+1); no wrap mid-frame.
REQ-024 o_max7219_data SHALL be 0 in IDLE, LOAD, DONE.

Reset
REQ-025 rst_n=0 at any time, including mid-frame, SHALL force IDLE immediately: load=0, data=0, clk=0, busy=0, done=0, counters and latched data cleared.
REQ-026 No partial frame SHALL resume after reset release; first accepted start begins a full frame.

Configuration
REQ-027 Macro MAX7219_CHAIN_IF_NOOP_MASK_EN defined: extra input i_word_mask [G_NB_MATRIX-1:0], latched with i_data; word k with mask bit 1 SHALL be shifted as 16'h0000 (no-op), frame length unchanged.
REQ-028 Macro undefined: port i_word_mask absent; all words shifted as latched.

Structure
REQ-029 Package max7219_pkg SHALL hold C_MAX7219_WORD_WIDTH=16, C_MAX7219_NOOP=16'h0000, and the FSM state enum.
REQ-030 One sub-module max7219_tick_timer (load/count/expire pulse) SHALL generate half-period and load-duration timing.

Verification
REQ-031 N=8,H=4,L=4, en_load=1, start with word7=16'h0C01, others 16'h0000 -> first 16 bits on DIN = 0C01 MSB first, then 112 zeros; 128 clk rising edges; load high 4 cycles; o_done at cycle 1029.
REQ-032 Same, en_load=0 -> no load pulse; o_done at cycle 1025.
REQ-033 Second i_start at cycle 100 of a frame -> ignored; exactly one o_done; data matches first request.
REQ-034 rst_n low at cycle 500 -> all outputs 0 same cycle; after release, new start produces full 1029-cycle frame.
REQ-035 N=1,H=1,L=1, word 16'hA5F0 -> 16 bits 1010010111110000, clk period 2 cycles, o_done at cycle 34.
REQ-036 NOOP_MASK_EN, mask=8'h02, all words 16'hFFFF -> bits of word 1 (positions 97..112 of frame) all 0, rest 1.
